// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: execution states, opcodes and
// the control bundle with its datapath write-mask helper.
package core_sequencer_pkg;

    localparam int BRANCH_DEPTH_W = 8;

    typedef enum logic [1:0] {
        CORE_S   = 2'd0,
        STALL_S  = 2'd1,
        BRANCH_S = 2'd2
    } core_state;

    typedef enum logic [3:0] {
        INC = 4'd0,
        DEC = 4'd1,
        MVR = 4'd2,
        MVL = 4'd3,
        CBF = 4'd4,
        CBB = 4'd5,
        PUT = 4'd6,
        GET = 4'd7,
        PSH = 4'd8,
        POP = 4'd9,
        HLT = 4'd10
    } op_code;

    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } write_en;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_WRITE = 2'd1,
        MEM_IDLE  = 2'd2
    } mem_op_t;

    typedef struct packed {
        core_state state;
        logic      pc_write;
        write_en   acc_write;
        write_en   stack_write;
        write_en   head_write;
        write_en   cache_write;
        mem_op_t   mem_op;
    } control_bundle_s;

    // Every datapath consumer masks through this so a stalled or scanning
    // core can never commit architectural state.
    function automatic control_bundle_s apply_write_mask(input control_bundle_s bundle,
                                                         input logic write_mask);
        control_bundle_s masked;
        masked = bundle;
        if (write_mask) begin
            masked.acc_write   = DISABLE;
            masked.stack_write = DISABLE;
            masked.head_write  = DISABLE;
            masked.cache_write = DISABLE;
            masked.mem_op      = MEM_READ;
        end
        return masked;
    endfunction

endpackage

// File: rtl/core_sequencer.sv
// Registered execution state of the core: passes decoder controls through in
// CORE_S, idles one cycle in STALL_S, and scans to the matching CBB in BRANCH_S.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CORE_S   | normal execution, decoder controls pass straight through
// STALL_S  | one idle cycle with writes masked, then the PC advances
// BRANCH_S | skip forward counting brace depth until the matching CBB
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int DEPTH_W = BRANCH_DEPTH_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  op_code             instruction,
    input  core_state          req_state,
    input  logic               req_pc_write,
    output core_state          state,
    output logic               write_mask,
    output logic               pc_write,
    output logic [DEPTH_W-1:0] branch_depth,
    output logic               depth_error
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    core_state          state_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CORE_S;
            depth_q <= '0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                CORE_S: begin
                    state_q <= req_state;
                    depth_q <= (req_state == BRANCH_S) ? DEPTH_ONE : '0;
                end
                STALL_S: begin
                    state_q <= CORE_S;
                    depth_q <= '0;
                end
                BRANCH_S: begin
                    case (instruction)
                        CBF: begin
                            if (depth_q == DEPTH_MAX) begin
                                error_q <= 1'b1;
                            end else begin
                                depth_q <= depth_q + DEPTH_ONE;
                            end
                        end
                        CBB: begin
                            // depth 0 should be unreachable here; treat it as a match
                            if (depth_q <= DEPTH_ONE) begin
                                state_q <= CORE_S;
                                depth_q <= '0;
                            end else begin
                                depth_q <= depth_q - DEPTH_ONE;
                            end
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state_q <= CORE_S;
                    depth_q <= '0;
                end
            endcase
        end
    end

    // An unknown encoding lasts one cycle; hold the datapath and PC still during it.
    always_comb begin
        write_mask = 1'b1;
        pc_write   = 1'b0;
        case (state_q)
            CORE_S: begin
                write_mask = 1'b0;
                pc_write   = req_pc_write;
            end
            STALL_S, BRANCH_S: begin
                write_mask = 1'b1;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state        = state_q;
    assign branch_depth = depth_q;
    assign depth_error  = error_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed tables, hand-written corner sequences and
// randomized stimulus against a behavioural model, on default and 2-bit depth.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    op_code    instr_a, instr_b;
    core_state req_a, req_b;
    logic      pcw_a, pcw_b;
    core_state state_a, state_b;
    logic      mask_a, mask_b, pc_a, pc_b, err_a, err_b;
    logic [7:0] depth_a;
    logic [1:0] depth_b;

    int checks = 0;
    int failures = 0;

    core_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .instruction(instr_a), .req_state(req_a),
        .req_pc_write(pcw_a), .state(state_a), .write_mask(mask_a),
        .pc_write(pc_a), .branch_depth(depth_a), .depth_error(err_a)
    );

    core_sequencer #(.DEPTH_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .instruction(instr_b), .req_state(req_b),
        .req_pc_write(pcw_b), .state(state_b), .write_mask(mask_b),
        .pc_write(pc_b), .branch_depth(depth_b), .depth_error(err_b)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        op_code    instr;
        core_state req;
        logic      pcw;
        core_state exp_state;
        logic      exp_mask;
        logic      exp_pcw;
        int        exp_depth;
    } vec_t;

    // Behavioural reference: the mode the core is in and how many braces are open.
    typedef struct {
        core_state mode;
        int        open_braces;
        bit        overflowed;
    } model_t;

    function automatic model_t model_next(input model_t m, input int max_depth,
                                          input op_code instr, input core_state req);
        model_t n;
        n = m;
        if (m.mode == CORE_S) begin
            n.mode = req;
            n.open_braces = (req == BRANCH_S) ? 1 : 0;
        end else if (m.mode == STALL_S) begin
            n.mode = CORE_S;
            n.open_braces = 0;
        end else begin
            if (instr == CBF) begin
                if (m.open_braces >= max_depth) n.overflowed = 1'b1;
                else n.open_braces = m.open_braces + 1;
            end else if (instr == CBB) begin
                n.open_braces = (m.open_braces > 0) ? m.open_braces - 1 : 0;
                if (n.open_braces == 0) n.mode = CORE_S;
            end
        end
        return n;
    endfunction

    function automatic op_code pick_op();
        op_code others[8] = '{INC, DEC, MVR, MVL, PUT, GET, PSH, POP};
        int r = $urandom_range(0, 99);
        if (r < 20) return CBF;
        if (r < 45) return CBB;
        return others[$urandom_range(0, 7)];
    endfunction

    function automatic core_state pick_req();
        int r = $urandom_range(0, 9);
        if (r < 6) return CORE_S;
        if (r < 8) return STALL_S;
        return BRANCH_S;
    endfunction

    vec_t stall_tbl[5];
    vec_t branch_tbl[8];
    model_t ma, mb;

    initial begin
        instr_a = INC; req_a = CORE_S; pcw_a = 1'b0;
        instr_b = INC; req_b = CORE_S; pcw_b = 1'b0;

        stall_tbl[0] = '{INC, CORE_S,   1'b1, CORE_S,  1'b0, 1'b1, 0};
        stall_tbl[1] = '{INC, CORE_S,   1'b1, CORE_S,  1'b0, 1'b1, 0};
        stall_tbl[2] = '{POP, STALL_S,  1'b0, CORE_S,  1'b0, 1'b0, 0};
        stall_tbl[3] = '{INC, BRANCH_S, 1'b0, STALL_S, 1'b1, 1'b1, 0};
        stall_tbl[4] = '{INC, CORE_S,   1'b0, CORE_S,  1'b0, 1'b0, 0};

        branch_tbl[0] = '{CBF, BRANCH_S, 1'b0, CORE_S,   1'b0, 1'b0, 0};
        branch_tbl[1] = '{INC, STALL_S,  1'b0, BRANCH_S, 1'b1, 1'b1, 1};
        branch_tbl[2] = '{CBF, CORE_S,   1'b0, BRANCH_S, 1'b1, 1'b1, 1};
        branch_tbl[3] = '{DEC, CORE_S,   1'b1, BRANCH_S, 1'b1, 1'b1, 2};
        branch_tbl[4] = '{CBB, CORE_S,   1'b0, BRANCH_S, 1'b1, 1'b1, 2};
        branch_tbl[5] = '{MVR, BRANCH_S, 1'b0, BRANCH_S, 1'b1, 1'b1, 1};
        branch_tbl[6] = '{CBB, CORE_S,   1'b0, BRANCH_S, 1'b1, 1'b1, 1};
        branch_tbl[7] = '{INC, CORE_S,   1'b1, CORE_S,   1'b0, 1'b1, 0};

        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_state", 32'(state_a), 32'(CORE_S));
        check("reset_depth", 32'(depth_a), 0);
        check("reset_err", 32'(err_a), 0);
        check("reset_mask", 32'(mask_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            instr_a = stall_tbl[i].instr; req_a = stall_tbl[i].req; pcw_a = stall_tbl[i].pcw;
            #1;
            check($sformatf("stall%0d_state", i), 32'(state_a), 32'(stall_tbl[i].exp_state));
            check($sformatf("stall%0d_mask", i), 32'(mask_a), 32'(stall_tbl[i].exp_mask));
            check($sformatf("stall%0d_pcw", i), 32'(pc_a), 32'(stall_tbl[i].exp_pcw));
            check($sformatf("stall%0d_depth", i), 32'(depth_a), 32'(stall_tbl[i].exp_depth));
            tick();
        end

        for (int i = 0; i < 8; i++) begin
            instr_a = branch_tbl[i].instr; req_a = branch_tbl[i].req; pcw_a = branch_tbl[i].pcw;
            #1;
            check($sformatf("branch%0d_state", i), 32'(state_a), 32'(branch_tbl[i].exp_state));
            check($sformatf("branch%0d_mask", i), 32'(mask_a), 32'(branch_tbl[i].exp_mask));
            check($sformatf("branch%0d_pcw", i), 32'(pc_a), 32'(branch_tbl[i].exp_pcw));
            check($sformatf("branch%0d_depth", i), 32'(depth_a), 32'(branch_tbl[i].exp_depth));
            tick();
        end

        // Saturation on the 2-bit instance: entry, then three CBF, then CBB.
        instr_b = CBF; req_b = BRANCH_S; pcw_b = 1'b0;
        tick();
        req_b = CORE_S;
        #1;
        check("sat_entry_depth", 32'(depth_b), 1);
        tick();
        #1;
        check("sat_cbf1_depth", 32'(depth_b), 2);
        check("sat_cbf1_err", 32'(err_b), 0);
        tick();
        #1;
        check("sat_cbf2_depth", 32'(depth_b), 3);
        check("sat_cbf2_err", 32'(err_b), 0);
        tick();
        #1;
        check("sat_cbf3_depth", 32'(depth_b), 3);
        check("sat_cbf3_err", 32'(err_b), 1);
        check("sat_state", 32'(state_b), 32'(BRANCH_S));
        instr_b = CBB;
        tick();
        #1;
        check("sat_cbb_depth", 32'(depth_b), 2);
        check("sat_cbb_err", 32'(err_b), 1);
        instr_b = INC;

        // Asynchronous reset in the middle of a branch at depth 3.
        instr_a = CBF; req_a = BRANCH_S;
        tick();
        req_a = CORE_S;
        tick();
        tick();
        #1;
        check("pre_reset_depth", 32'(depth_a), 3);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state_a), 32'(CORE_S));
        check("async_reset_depth", 32'(depth_a), 0);
        check("async_reset_err", 32'(err_a), 0);
        check("async_reset_mask", 32'(mask_a), 0);
        check("async_reset_err_b", 32'(err_b), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        ma = '{CORE_S, 0, 1'b0};
        mb = '{CORE_S, 0, 1'b0};
        for (int i = 0; i < 3000; i++) begin
            instr_a = pick_op(); req_a = pick_req(); pcw_a = 1'($urandom_range(0, 1));
            instr_b = pick_op(); req_b = pick_req(); pcw_b = 1'($urandom_range(0, 1));
            #1;
            check("rand_a_state", 32'(state_a), 32'(ma.mode));
            check("rand_a_mask", 32'(mask_a), 32'(ma.mode != CORE_S));
            check("rand_a_pcw", 32'(pc_a), (ma.mode == CORE_S) ? 32'(pcw_a) : 32'd1);
            check("rand_a_depth", 32'(depth_a), 32'(ma.open_braces));
            check("rand_a_err", 32'(err_a), 32'(ma.overflowed));
            check("rand_b_state", 32'(state_b), 32'(mb.mode));
            check("rand_b_mask", 32'(mask_b), 32'(mb.mode != CORE_S));
            check("rand_b_pcw", 32'(pc_b), (mb.mode == CORE_S) ? 32'(pcw_b) : 32'd1);
            check("rand_b_depth", 32'(depth_b), 32'(mb.open_braces));
            check("rand_b_err", 32'(err_b), 32'(mb.overflowed));
            ma = model_next(ma, 255, instr_a, req_a);
            mb = model_next(mb, 3, instr_b, req_b);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
